// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//   Takes single read/write requests from a local requester and runs the APB
//   SETUP/ACCESS handshake towards NUM_SLV slaves. The slave is selected by
//   the top address bits. The bridge returns read data and an error flag as
//   a one-cycle completion pulse. Back-to-back requests skip the IDLE cycle.
//   An ACCESS phase that stalls for TIMEOUT cycles is force-completed with an
//   error.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   transfer, req_write      request valid and direction (1 = write)
//   req_addr, req_wdata      request address and write data
//   req_ready                request accepted this cycle (combinational)
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata, rsp_err       read data and error flag, valid with rsp_valid
//   pselx, penable, pwrite   APB control towards the slaves
//   paddr, pwdata            APB address and write data
//   prdata, pready, pslverr  APB responses from the selected slave
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                transfer,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [NUM_SLV-1:0]  pselx,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    // A single slave still needs a legal 1-bit slice for the decoder.
    // The decoder ignores that slice when NUM_SLV is 1.
    localparam int SEL_IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t             cs;
    state_t             ns;
    logic [CNT_W-1:0]   cnt;
    logic               done;
    logic               accept;
    logic [NUM_SLV-1:0] sel_d;

    function automatic logic [NUM_SLV-1:0] decode(input logic [SEL_IDX_W-1:0] s);
        logic [NUM_SLV-1:0] one;
        one = NUM_SLV'(1);
        if (NUM_SLV == 1)
            return one;
        else
            return one << s;
    endfunction

    always_comb begin
        done      = (cs == ACCESS) && (pready || (cnt == CNT_LAST));
        req_ready = (cs == IDLE) || done;
        accept    = transfer && req_ready;

        ns = cs;
        case (cs)
            IDLE:    if (accept) ns = SETUP;
            SETUP:   ns = ACCESS;
            ACCESS:  if (done) ns = accept ? SETUP : IDLE;
            default: ns = IDLE;
        endcase

        // Select lines are registered from the next state.
        // A new SETUP therefore decodes the incoming address, not paddr.
        sel_d = '0;
        if (ns == SETUP)
            sel_d = decode(req_addr[ADDR_W-1 -: SEL_IDX_W]);
        else if (ns == ACCESS)
            sel_d = pselx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs        <= IDLE;
            cnt       <= '0;
            pselx     <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            cs        <= ns;
            pselx     <= sel_d;
            penable   <= (ns == ACCESS);
            rsp_valid <= done;

            if (accept) begin
                pwrite <= req_write;
                paddr  <= req_addr;
                pwdata <= req_wdata;
            end

            if (cs == SETUP)
                cnt <= '0;
            else if ((cs == ACCESS) && !done)
                cnt <= cnt + CNT_W'(1);

            // A timeout completes without pready.
            // It reports an error and leaves the last read data in place.
            if (done) begin
                rsp_err <= pready ? pslverr : 1'b1;
                if (pready && !pwrite)
                    rsp_rdata <= prdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//   Scoreboard bench for apb_master_bridge (default parameters).
//   Stimulus drives directed and random requests. For each accepted request
//   it pushes a slave behaviour plan and the expected response. A slave
//   model answers the APB bus according to the plan. A monitor pops the
//   expected response whenever rsp_valid is seen and compares it.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_SLV = 4;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              transfer;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [NUM_SLV-1:0] pselx;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    apb_master_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .transfer(transfer), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          w;      // wait cycles before pready; >= TIMEOUT means never
        logic        err;
        logic [31:0] prd;
    } plan_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    plan_t       plan_q[$];
    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] model_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] onehot(input logic [31:0] a);
        return 4'b0001 << a[31:30];
    endfunction

    // Slave model: reacts to bus state shortly after each rising edge.
    plan_t cur;
    int    k = 0;
    logic  active = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            active  = 1'b0;
            k       = 0;
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = '0;
        end else if ((pselx != 0) && !penable) begin
            if (plan_q.size() == 0) begin
                total++; bad++;
                $display("FAIL setup_without_request: got pselx=%0h expected no transfer", pselx);
            end else begin
                cur    = plan_q.pop_front();
                active = 1'b1;
                k      = 0;
                chk("setup_pselx", pselx, onehot(cur.addr));
                chk("setup_paddr", paddr, cur.addr);
                chk("setup_pwrite", pwrite, cur.wr);
                if (cur.wr) chk("setup_pwdata", pwdata, cur.wdata);
            end
            // Noise that the bridge must ignore outside ACCESS.
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = $urandom;
        end else if (penable) begin
            if (!active) begin
                total++; bad++;
                $display("FAIL access_without_setup: got penable=1 expected 0");
            end
            chk("access_pselx", pselx, onehot(cur.addr));
            chk("access_paddr", paddr, cur.addr);
            if ((cur.w < TIMEOUT) && (k == cur.w)) begin
                pready  = 1'b1;
                pslverr = cur.err;
                prdata  = cur.prd;
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
            k++;
        end else begin
            active  = 1'b0;
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = $urandom;
        end
    end

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    // Issues one request and waits until it is accepted. The task is
    // entered and left just after a rising edge. keep=1 leaves transfer
    // high so the next call can follow back-to-back.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int w, input logic err, input logic [31:0] prd,
                        input bit keep, output int acc);
        plan_t p;
        exp_t  e;
        int    n;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        transfer  = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 100) begin
                $display("FAIL accept_timeout: got req_ready=0 expected 1 within 100 cycles");
                $fatal(1, "request never accepted");
            end
        end
        p.addr = addr; p.wr = wr; p.wdata = wdata; p.w = w; p.err = err; p.prd = prd;
        plan_q.push_back(p);
        acc   = cyc + 1;
        e.acc = acc;
        if (w >= TIMEOUT) begin
            e.err = 1'b1;
            e.lat = 1 + TIMEOUT;
        end else begin
            e.err = err;
            e.lat = 2 + w;
            if (!wr) model_rdata = prd;
        end
        e.rdata = model_rdata;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) transfer = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < 300)) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_exp_q", exp_q.size(), 0);
        chk("drain_plan_q", plan_q.size(), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_pselx"}, pselx, 0);
        chk({tag, "_penable"}, penable, 0);
        chk({tag, "_pwrite"}, pwrite, 0);
        chk({tag, "_paddr"}, paddr, 0);
        chk({tag, "_pwdata"}, pwdata, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, acc, r, w, gap;
        logic keep;
        rst = 1'b1; transfer = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_req_ready", req_ready, 1);
        @(posedge clk);
        #1;

        // Zero-wait write to slave 1.
        send(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0, acc);
        drain();
        // Read with three wait states from slave 3.
        send(1'b0, 32'hC000_0004, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0, acc);
        drain();
        // Read completing with a slave error.
        send(1'b0, 32'h2000_0008, 32'h0, 1, 1'b1, 32'hA5A5_A5A5, 1'b0, acc);
        drain();
        // Back-to-back writes to slave 0 then slave 2.
        send(1'b1, 32'h0000_0000, 32'h1111_1111, 0, 1'b0, 32'h0, 1'b1, a1);
        send(1'b1, 32'h8000_0000, 32'h2222_2222, 0, 1'b0, 32'h0, 1'b0, a2);
        chk("b2b_spacing", a2 - a1, 2);
        drain();
        // Read that never sees pready: forced error, data unchanged.
        send(1'b0, 32'h5000_0000, 32'h0, NEVER, 1'b0, 32'hFFFF_0000, 1'b0, acc);
        drain();

        // Reset asserted in the second ACCESS cycle of a stalled write.
        send(1'b1, 32'h3000_0000, 32'h0000_CAFE, NEVER, 1'b0, 32'h0, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_penable", penable, 1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        exp_q.delete();
        plan_q.delete();
        model_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", req_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_no_rsp", rsp_valid, 0);
        end
        @(posedge clk);
        #1;

        // Random traffic with mixed wait states, errors, timeouts and gaps.
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom % 10);
            if (r < 5)       w = 0;
            else if (r < 8)  w = int'($urandom % 4);
            else if (r == 8) w = TIMEOUT - 1;
            else             w = NEVER;
            keep = (i != 149) && (($urandom % 2) == 1);
            send(1'($urandom), $urandom, $urandom, w, ($urandom % 4) == 0, $urandom, keep, acc);
            if (!keep) begin
                gap = int'($urandom % 3);
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();

        @(negedge clk);
        chk("final_req_ready", req_ready, 1);
        chk("final_penable", penable, 0);
        chk("final_pselx", pselx, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Parametrised APB master bridge: accepts single read/write requests from a local requester, runs the APB SETUP/ACCESS protocol towards NUM_SLV address-decoded slaves, and returns read data and an error flag. It replaces the fixed single-slave IDLE/SETUP/ACCESS master FSM. Over that block it adds configurable address/data width, multiple slave selects, back-to-back transfers without an IDLE cycle, PSLVERR propagation and a wait-state timeout.

## Interface
Parameters:
- ADDR_W, 32, address width; top SEL_W = $clog2(NUM_SLV) bits select the slave
- DATA_W, 32, data width
- NUM_SLV, 4, number of slaves; power of two, 1..16; SEL_W = 0 when NUM_SLV = 1
- TIMEOUT, 16, maximum ACCESS cycles before forced error completion; >= 2

Ports:
- clk, input, 1, clock; all logic on rising edge
- rst, input, 1, reset; asynchronous, active-high
- transfer, input, 1, request valid
- req_write, input, 1, 1 = write, 0 = read
- req_addr, input, ADDR_W, request address
- req_wdata, input, DATA_W, write data
- req_ready, output, 1, request accepted this cycle when transfer is also high
- rsp_valid, output, 1, one-cycle completion pulse
- rsp_rdata, output, DATA_W, read data; valid with rsp_valid on reads
- rsp_err, output, 1, slave error or timeout; valid with rsp_valid
- pselx, output, NUM_SLV, one-hot slave select
- penable, output, 1, APB enable
- pwrite, output, 1, APB direction
- paddr, output, ADDR_W, APB address
- pwdata, output, DATA_W, APB write data
- prdata, input, DATA_W, APB read data
- pready, input, 1, slave ready
- pslverr, input, 1, slave error

## Operation
- States: IDLE (0), SETUP (1), ACCESS (2). State is encoded in a register named cs.
- req_ready is combinational.
  - High in IDLE.
  - High in ACCESS on the completing cycle: pready = 1, or timeout count = TIMEOUT-1.
  - Low otherwise.
- Acceptance (transfer & req_ready at a rising edge):
  - Register req_write into pwrite, req_addr into paddr, req_wdata into pwdata.
  - Next state is SETUP.
- IDLE:
  - pselx = 0, penable = 0.
  - Exit to SETUP on acceptance; otherwise stay.
- SETUP:
  - pselx[paddr[ADDR_W-1 -: SEL_W]] = 1, penable = 0.
  - Always exit to ACCESS after one cycle. Clear the timeout counter.
- ACCESS:
  - Same pselx as SETUP, penable = 1.
  - pready = 1: complete. Set rsp_err = pslverr. Set rsp_rdata = prdata on reads; hold the previous value on writes.
  - pready = 0 and counter = TIMEOUT-1: complete with rsp_err = 1. rsp_rdata is unchanged.
  - pready = 0 otherwise: increment the counter and stay in ACCESS.
- On completion:
  - With a new acceptance in the same cycle, go directly to SETUP (back-to-back).
  - Otherwise go to IDLE.
- paddr, pwrite and pwdata are held stable from SETUP through the final ACCESS cycle. They keep their last value in IDLE.
- pready and pslverr are ignored outside ACCESS.
- Reset value of every output is 0: pselx, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err. cs = IDLE, counter = 0.
- Reset asserted mid-transfer:
  - All outputs clear immediately (asynchronously).
  - No rsp_valid is generated.
  - The interrupted request is dropped.

## Timing
- Accept at edge E0. SETUP spans E0–E1. ACCESS starts at E1.
- Zero wait states:
  - Completion is sampled at E2.
  - rsp_valid is high E2–E3, with rsp_rdata and rsp_err registered at E2.
  - Request-to-response latency is 2 cycles.
- Each cycle of pready = 0 in ACCESS adds 1 cycle of latency, up to TIMEOUT ACCESS cycles in total.
- Back-to-back throughput: one transfer per 2 + wait cycles; no IDLE cycle between transfers.
- rsp_valid is a registered pulse, high for exactly one cycle per completed transfer.
- pselx and penable are registered from the next-state logic.
- Outputs never glitch between SETUP and ACCESS.

## Test plan
- Reset during ACCESS:
  - Stimulus: write to 0x3000_0000, pready held 0, rst = 1 on the 2nd ACCESS cycle.
  - Response: pselx, penable and all outputs 0 immediately; no rsp_valid; after rst = 0 the bridge sits in IDLE with req_ready = 1.
- Zero-wait write:
  - Stimulus: transfer = 1, req_write = 1, req_addr = 0x4000_0010, req_wdata = 0xDEAD_BEEF, pready = 1.
  - Response: pselx = 4'b0010 for 2 cycles; penable high for 1 cycle; rsp_valid 2 cycles after acceptance; rsp_err = 0.
- Read with 3 wait states:
  - Stimulus: read from 0xC000_0004; pready = 0 for 3 ACCESS cycles, then 1 with prdata = 0x1234_5678.
  - Response: pselx = 4'b1000; ACCESS lasts 4 cycles; rsp_rdata = 0x1234_5678; latency 5.
- Slave error:
  - Stimulus: read completing with pslverr = 1.
  - Response: rsp_err = 1 alongside rsp_valid.
- Back-to-back:
  - Stimulus: transfer held high for writes to 0x0000_0000 then 0x8000_0000, both zero-wait.
  - Response: SETUP of the 2nd write follows the 1st ACCESS with no IDLE; pselx changes 4'b0001 to 4'b0100; two rsp_valid pulses 2 cycles apart.
- Timeout:
  - Stimulus: TIMEOUT = 16, pready never asserted.
  - Response: exactly 16 ACCESS cycles; rsp_valid with rsp_err = 1; return to IDLE; rsp_rdata unchanged.
